// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the programmable synchronous FIFO.
// The pointer increment wraps explicitly, so depths do not need to be a power of two.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  // Advance a pointer by one and wrap to zero after the last entry (depth-1).
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_prog: one synchronous write port, one asynchronous read port.
// Contents are not reset; occupancy tracking in the top decides which words are meaningful.
module sync_fifo_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; otherwise data_out is registered.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int FIFO_Depth = DEF_DEPTH,
  parameter  int AF_THRESH  = FIFO_Depth - 2,
  parameter  int AE_THRESH  = 2,
  localparam int CW         = $clog2(FIFO_Depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int AW = (FIFO_Depth > 1) ? $clog2(FIFO_Depth) : 1;

  if (FIFO_Depth < 2 || AE_THRESH >= AF_THRESH || AF_THRESH > FIFO_Depth) begin : g_bad_cfg
    $fatal(1, "sync_fifo_prog: need FIFO_Depth>=2 and AE_THRESH < AF_THRESH <= FIFO_Depth");
  end

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rdata;

  // Status is decoded from the registered count only.
  assign count        = count_q;
  assign full         = (count_q == CW'(FIFO_Depth));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // Handshake: wr_en is accepted only while !full and rd_en only while !empty, both judged
  // on pre-edge state; a request made while blocked is dropped and latched as overflow/underflow.
  always_comb begin
    wr_acc   = wr_en && !full;
    rd_acc   = rd_en && !empty;
    wr_ptr_d = wr_acc ? AW'(ptr_inc(32'(wr_ptr_q), 32'(FIFO_Depth))) : wr_ptr_q;
    rd_ptr_d = rd_acc ? AW'(ptr_inc(32'(rd_ptr_q), 32'(FIFO_Depth))) : rd_ptr_q;
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    ovf_d    = (wr_en && full)  ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
    unf_d    = (rd_en && empty) ? 1'b1 : (clr_err ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sync_fifo_mem #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_Depth),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is visible as soon as it is stored; meaningless while empty.
  assign data_out = rdata;
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= rdata;
    end
  end

  assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: a queue-based reference model tracks the expected
// contents, flags and output word; each scenario task checks the DUT against it inline.
module tb_sync_fifo_prog;

  localparam int D  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, clr_err;
  logic [7:0]    data_in, data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] count;

  logic          wr5, rd5;
  logic [7:0]    din5, dout5;
  logic          full5, empty5, af5, ae5, ovf5, unf5;
  logic [2:0]    count5;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_dout;
  bit         exp_ovf, exp_unf;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(8), .FIFO_Depth(D)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  sync_fifo_prog #(.DATA_WIDTH(8), .FIFO_Depth(5), .AF_THRESH(3), .AE_THRESH(2)) dut5 (
    .clk(clk), .rst(rst), .wr_en(wr5), .data_in(din5), .rd_en(rd5),
    .data_out(dout5), .full(full5), .empty(empty5), .almost_full(af5),
    .almost_empty(ae5), .count(count5), .overflow(ovf5),
    .underflow(unf5), .clr_err(clr_err)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // In FWFT mode the output word is only meaningful while the FIFO holds data.
  function automatic bit dout_checkable();
`ifdef SYNC_FIFO_FWFT_EN
    return exp_q.size() != 0;
`else
    return 1'b1;
`endif
  endfunction

  // Drive one clock of stimulus and advance the reference model by the FIFO rules.
  task automatic step(input bit r_rst, input bit w, input logic [7:0] d, input bit r, input bit c);
    bit full_m, empty_m;
    rst = r_rst; wr_en = w; data_in = d; rd_en = r; clr_err = c;
    full_m  = (exp_q.size() == D);
    empty_m = (exp_q.size() == 0);
    @(posedge clk);
    #1;
    if (r_rst) begin
      exp_q.delete();
      exp_dout = 8'h00;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
    end else begin
      if (w && full_m) exp_ovf = 1'b1;
      else if (c)      exp_ovf = 1'b0;
      if (r && empty_m) exp_unf = 1'b1;
      else if (c)       exp_unf = 1'b0;
      if (r && !empty_m) exp_dout = exp_q.pop_front();
      if (w && !full_m)  exp_q.push_back(d);
`ifdef SYNC_FIFO_FWFT_EN
      if (exp_q.size() != 0) exp_dout = exp_q[0];
`endif
    end
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    checks++; if (count !== 5'd0)   begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0)    begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae: got %b want 1", almost_empty); end
    checks++; if (almost_full !== 1'b0)  begin errors++; $display("FAIL reset_af: got %b want 0", almost_full); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0)
      begin errors++; $display("FAIL reset_err: got ovf=%b unf=%b want 0/0", overflow, underflow); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", data_out); end
`endif
    for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom_range(0, 255)), 0, 0);
    step(0, 1, 8'hEE, 1, 0);
    step(1, 1, 8'hEE, 1, 1);
    step(1, 1, 8'hEE, 1, 1);
    checks++; if (count !== 5'd0)   begin errors++; $display("FAIL midreset_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0)
      begin errors++; $display("FAIL midreset_flags: got e=%b ae=%b f=%b af=%b want 1 1 0 0", empty, almost_empty, full, almost_full); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midreset_dout: got %h want 00", data_out); end
`endif
    step(0, 0, 8'h00, 1, 0);
    checks++; if (underflow !== 1'b1 || count !== 5'd0)
      begin errors++; $display("FAIL midreset_unreadable: got unf=%b count=%0d want 1 0", underflow, count); end
    step(0, 0, 8'h00, 0, 1);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL midreset_clr: got %b want 0", underflow); end
  endtask

  task automatic test_fill_drain();
    step(1, 0, 8'h00, 0, 0);
    for (int i = 1; i <= D; i++) begin
      step(0, 1, 8'(i), 0, 0);
      checks++; if (count !== CW'(i)) begin errors++; $display("FAIL fill_count: got %0d want %0d", count, i); end
      checks++; if (almost_full !== (i >= 14)) begin errors++; $display("FAIL fill_af: at %0d got %b", i, almost_full); end
      checks++; if (full !== (i == D)) begin errors++; $display("FAIL fill_full: at %0d got %b", i, full); end
    end
    for (int i = 1; i <= D; i++) begin
      step(0, 0, 8'h00, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
      checks++; if (data_out !== 8'(i)) begin errors++; $display("FAIL drain_data: got %h want %h", data_out, 8'(i)); end
`else
      if (i < D) begin
        checks++; if (data_out !== 8'(i + 1)) begin errors++; $display("FAIL drain_data: got %h want %h", data_out, 8'(i + 1)); end
      end
`endif
      checks++; if (count !== CW'(D - i)) begin errors++; $display("FAIL drain_count: got %0d want %0d", count, D - i); end
      checks++; if (almost_empty !== (D - i <= 2)) begin errors++; $display("FAIL drain_ae: at %0d got %b", D - i, almost_empty); end
      checks++; if (empty !== (i == D)) begin errors++; $display("FAIL drain_empty: at %0d got %b", D - i, empty); end
    end
  endtask

  task automatic test_overflow();
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < D; i++) step(0, 1, 8'($urandom_range(0, 127)), 0, 0);
    step(0, 1, 8'hAA, 0, 0);
    checks++; if (overflow !== 1'b1 || count !== 5'd16)
      begin errors++; $display("FAIL ovf_set: got ovf=%b count=%0d want 1 16", overflow, count); end
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    step(0, 0, 8'h00, 0, 1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", overflow); end
    step(0, 1, 8'hAA, 1, 0);
    checks++; if (overflow !== 1'b1 || count !== 5'd15)
      begin errors++; $display("FAIL ovf_rdwr: got ovf=%b count=%0d want 1 15", overflow, count); end
    checks++; if (data_out !== exp_dout) begin errors++; $display("FAIL ovf_rdwr_data: got %h want %h", data_out, exp_dout); end
    step(0, 0, 8'h00, 0, 1);
    while (exp_q.size() != 0) begin
      step(0, 0, 8'h00, 1, 0);
      if (dout_checkable()) begin
        checks++; if (data_out !== exp_dout || data_out === 8'hAA)
          begin errors++; $display("FAIL ovf_drain: got %h want %h", data_out, exp_dout); end
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_final_empty: got %b want 1", empty); end
  endtask

  task automatic test_underflow();
    step(1, 0, 8'h00, 0, 0);
    step(0, 1, 8'h55, 1, 0);
    checks++; if (underflow !== 1'b1 || count !== 5'd1 || empty !== 1'b0)
      begin errors++; $display("FAIL unf_set: got unf=%b count=%0d empty=%b want 1 1 0", underflow, count, empty); end
`ifdef SYNC_FIFO_FWFT_EN
    checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL unf_head: got %h want 55", data_out); end
`endif
    step(0, 0, 8'h00, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL unf_read: got %h want 55", data_out); end
`endif
    checks++; if (count !== 5'd0 || empty !== 1'b1)
      begin errors++; $display("FAIL unf_after_read: got count=%0d empty=%b want 0 1", count, empty); end
    step(0, 0, 8'h00, 1, 1);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_set_beats_clr: got %b want 1", underflow); end
    step(0, 0, 8'h00, 0, 1);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clr: got %b want 0", underflow); end
  endtask

  task automatic test_random();
    int wp, rp;
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 500; i++) begin
      wp = ((i / 100) % 2 == 0) ? 75 : 25;
      rp = 100 - wp;
      step(0, $urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp, $urandom_range(0, 15) == 0);
      checks++; if (count !== CW'(exp_q.size())) begin errors++; $display("FAIL rnd_count: cyc %0d got %0d want %0d", i, count, exp_q.size()); end
      checks++; if (full !== (exp_q.size() == D) || empty !== (exp_q.size() == 0))
        begin errors++; $display("FAIL rnd_full_empty: cyc %0d got f=%b e=%b size %0d", i, full, empty, exp_q.size()); end
      checks++; if (almost_full !== (exp_q.size() >= 14) || almost_empty !== (exp_q.size() <= 2))
        begin errors++; $display("FAIL rnd_almost: cyc %0d got af=%b ae=%b size %0d", i, almost_full, almost_empty, exp_q.size()); end
      checks++; if (overflow !== exp_ovf || underflow !== exp_unf)
        begin errors++; $display("FAIL rnd_err: cyc %0d got ovf=%b unf=%b want %b %b", i, overflow, underflow, exp_ovf, exp_unf); end
      if (dout_checkable()) begin
        checks++; if (data_out !== exp_dout) begin errors++; $display("FAIL rnd_data: cyc %0d got %h want %h", i, data_out, exp_dout); end
      end
    end
  endtask

  task automatic test_wrap5();
    logic [7:0] q5[$];
    logic [7:0] popped, want;
    step(1, 0, 8'h00, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      wr5 = 1'b1; din5 = 8'(i); q5.push_back(8'(i));
      @(posedge clk); #1;
    end
    wr5 = 1'b0;
    checks++; if (count5 !== 3'd3 || af5 !== 1'b1 || ae5 !== 1'b0)
      begin errors++; $display("FAIL wrap_prefill: got count=%0d af=%b ae=%b want 3 1 0", count5, af5, ae5); end
    for (int k = 0; k < 12; k++) begin
      wr5 = 1'b1; rd5 = 1'b1; din5 = 8'h10 + 8'(k);
      popped = q5.pop_front();
      q5.push_back(din5);
      @(posedge clk); #1;
`ifdef SYNC_FIFO_FWFT_EN
      want = q5[0];
`else
      want = popped;
`endif
      checks++; if (dout5 !== want) begin errors++; $display("FAIL wrap_data: pair %0d got %h want %h", k, dout5, want); end
      checks++; if (count5 !== 3'd3) begin errors++; $display("FAIL wrap_count: pair %0d got %0d want 3", k, count5); end
    end
    wr5 = 1'b0; rd5 = 1'b0;
    checks++; if (full5 !== 1'b0 || empty5 !== 1'b0 || ovf5 !== 1'b0 || unf5 !== 1'b0)
      begin errors++; $display("FAIL wrap_flags: got f=%b e=%b ovf=%b unf=%b want 0 0 0 0", full5, empty5, ovf5, unf5); end
  endtask

  task automatic test_first_word();
    step(1, 0, 8'h00, 0, 0);
    step(0, 1, 8'h33, 0, 0);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fw_empty: got %b want 0", empty); end
`ifdef SYNC_FIFO_FWFT_EN
    checks++; if (data_out !== 8'h33) begin errors++; $display("FAIL fw_fwft_data: got %h want 33", data_out); end
`else
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL fw_latency_hold: got %h want 00", data_out); end
`endif
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (data_out !== 8'h33) begin errors++; $display("FAIL fw_read_data: got %h want 33", data_out); end
`endif
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fw_empty_after: got %b want 1", empty); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = 8'h00;
    wr5 = 1'b0; rd5 = 1'b0; din5 = 8'h00;
    exp_dout = 8'h00; exp_ovf = 1'b0; exp_unf = 1'b0;
    #2;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_random();
    test_wrap5();
    test_first_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
